// File: rtl/bglc_pkg.sv
// Shared types and register map for the background layer compositor.
// Imported by bg_layer_compositor and bglc_layer_scroll.
package bglc_pkg;

   localparam logic [5:0] A_CTRL   = 6'h00;
   localparam logic [5:0] A_STATUS = 6'h04;
   localparam logic [5:0] A_FCNT   = 6'h08;
   localparam logic [5:0] A_BG     = 6'h0C;
   localparam logic [5:0] A_SPEED  = 6'h10;
   localparam logic [5:0] A_OFS    = 6'h20;

   // {R[1:0], G[1:0], B[1:0]}
   typedef logic [5:0] rgb222_t;

   typedef struct packed {
      logic    opaque;
      rgb222_t rgb;
   } layer_pix_t;

   // Output pins carry {B, G, R}
   function automatic logic [5:0] to_bgr(input rgb222_t c);
      return {c[1:0], c[3:2], c[5:4]};
   endfunction

endpackage

// File: rtl/bglc_layer_scroll.sv
// Per-layer scroll state: speed, live offset and pending offset.
// Produces the scrolled coordinates handed to one background generator.
module bglc_layer_scroll
   import bglc_pkg::*;
#(
   parameter int COORD_W = 11,
   parameter int SPEED_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               speed_we,
   input  logic               ofs_we,
   input  logic               tick,
   input  logic               en,
   input  logic [SPEED_W-1:0] wdx,
   input  logic [SPEED_W-1:0] wdy,
   input  logic [COORD_W-1:0] wx,
   input  logic [COORD_W-1:0] wy,
   input  logic [COORD_W-1:0] pix_x,
   input  logic [COORD_W-1:0] pix_y,
   output logic [SPEED_W-1:0] dx,
   output logic [SPEED_W-1:0] dy,
   output logic [COORD_W-1:0] x_ofs,
   output logic [COORD_W-1:0] y_ofs,
   output logic [COORD_W-1:0] layer_x,
   output logic [COORD_W-1:0] layer_y
);

   logic               pend;
   logic [COORD_W-1:0] px;
   logic [COORD_W-1:0] py;
   logic [COORD_W-1:0] dx_s;
   logic [COORD_W-1:0] dy_s;

   assign dx_s = {{(COORD_W-SPEED_W){dx[SPEED_W-1]}}, dx};
   assign dy_s = {{(COORD_W-SPEED_W){dy[SPEED_W-1]}}, dy};

   assign layer_x = pix_x + x_ofs;
   assign layer_y = pix_y + y_ofs;

   // Speed register, written directly from the bus
   always_ff @(posedge clk) begin
      if (rst) begin
         dx <= '0;
         dy <= '0;
      end else if (speed_we) begin
         dx <= wdx;
         dy <= wdy;
      end
   end

   // Frame step: a pending write wins over the speed step;
   // a write landing on the tick stays pending for the next one
   always_ff @(posedge clk) begin
      if (rst) begin
         x_ofs <= '0;
         y_ofs <= '0;
         pend  <= 1'b0;
         px    <= '0;
         py    <= '0;
      end else begin
         if (tick) begin
            if (pend) begin
               x_ofs <= px;
               y_ofs <= py;
            end else if (en) begin
               x_ofs <= x_ofs + dx_s;
               y_ofs <= y_ofs + dy_s;
            end
         end
         if (ofs_we) begin
            pend <= 1'b1;
            px   <= wx;
            py   <= wy;
         end else if (tick) begin
            pend <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/bg_layer_compositor.sv
// Multi-layer scrolling background compositor on the TinyQV peripheral bus.
// Optional frame interrupt: define BGLC_FRAME_IRQ_EN.
module bg_layer_compositor
   import bglc_pkg::*;
#(
   parameter int NUM_LAYERS = 3,
   parameter int COORD_W    = 11,
   parameter int SPEED_W    = 4,
   parameter int FCNT_W     = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [5:0]                    address,
   input  logic [31:0]                   data_in,
   input  logic [1:0]                    data_write_n,
   input  logic [1:0]                    data_read_n,
   output logic [31:0]                   data_out,
   output logic                          data_ready,
   output logic                          user_interrupt,
   input  logic [COORD_W-1:0]            pix_x,
   input  logic [COORD_W-1:0]            pix_y,
   input  logic                          visible,
   input  logic                          hsync_in,
   input  logic                          vsync_in,
   output logic [NUM_LAYERS*COORD_W-1:0] layer_x,
   output logic [NUM_LAYERS*COORD_W-1:0] layer_y,
   input  logic [NUM_LAYERS*7-1:0]       layer_pix,
   output logic [7:0]                    uo_rgb
);

   localparam logic [7:0] CTRL_MASK =
      8'h80 | 8'((1 << (NUM_LAYERS + 1)) - 1);

   logic [7:0]        ctrl;
   logic [FCNT_W-1:0] fcnt;
   rgb222_t           bg;
   logic              vsync_d;
   logic              wr;
   logic              tick;
   logic              frame_pend;
   rgb222_t           pick;
   logic              unused;

   logic [NUM_LAYERS-1:0] spd_hit;
   logic [NUM_LAYERS-1:0] ofs_hit;
   logic [SPEED_W-1:0]    dx    [NUM_LAYERS];
   logic [SPEED_W-1:0]    dy    [NUM_LAYERS];
   logic [COORD_W-1:0]    x_ofs [NUM_LAYERS];
   logic [COORD_W-1:0]    y_ofs [NUM_LAYERS];
   layer_pix_t            lp    [NUM_LAYERS];

   assign data_ready = 1'b1;
   assign wr         = data_write_n != 2'b11;
   assign tick       = vsync_in & ~vsync_d & ctrl[0];
   assign unused     = ^{data_read_n, data_in};

   // Control, colour and frame counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl    <= '0;
         fcnt    <= '0;
         bg      <= '0;
         vsync_d <= 1'b0;
      end else begin
         vsync_d <= vsync_in;
         if (tick)
            fcnt <= fcnt + FCNT_W'(1);
         if (wr && address == A_CTRL)
            ctrl <= data_in[7:0] & CTRL_MASK;
         if (wr && address == A_BG)
            bg <= data_in[5:0];
      end
   end

`ifdef BGLC_FRAME_IRQ_EN
   // Frame interrupt flag; a set on the tick beats a W1C
   always_ff @(posedge clk) begin
      if (rst)
         frame_pend <= 1'b0;
      else if (tick && ctrl[7])
         frame_pend <= 1'b1;
      else if (wr && address == A_STATUS && data_in[0])
         frame_pend <= 1'b0;
   end
   assign user_interrupt = frame_pend;
`else
   assign frame_pend     = 1'b0;
   assign user_interrupt = 1'b0;
`endif

   for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_layer
      assign spd_hit[i] = address[5:4] == A_SPEED[5:4] &&
                          address[1:0] == 2'b00 &&
                          {1'b0, address[3:2]} == 3'(i);
      assign ofs_hit[i] = address[5] &&
                          address[1:0] == 2'b00 &&
                          address[4:2] == 3'(i);
      assign lp[i]      = layer_pix[i*7 +: 7];

      bglc_layer_scroll #(
         .COORD_W (COORD_W),
         .SPEED_W (SPEED_W)
      ) u_scroll (
         .clk      (clk),
         .rst      (rst),
         .speed_we (wr & spd_hit[i]),
         .ofs_we   (wr & ofs_hit[i]),
         .tick     (tick),
         .en       (ctrl[i+1]),
         .wdx      (data_in[SPEED_W-1:0]),
         .wdy      (data_in[SPEED_W+7:8]),
         .wx       (data_in[COORD_W-1:0]),
         .wy       (data_in[COORD_W+15:16]),
         .pix_x    (pix_x),
         .pix_y    (pix_y),
         .dx       (dx[i]),
         .dy       (dy[i]),
         .x_ofs    (x_ofs[i]),
         .y_ofs    (y_ofs[i]),
         .layer_x  (layer_x[i*COORD_W +: COORD_W]),
         .layer_y  (layer_y[i*COORD_W +: COORD_W])
      );
   end

   // Fixed priority: lowest enabled opaque layer wins
   always_comb begin
      pick = bg;
      for (int i = NUM_LAYERS - 1; i >= 0; i--)
         if (ctrl[i+1] && lp[i].opaque)
            pick = lp[i].rgb;
   end

   // Registered pixel with syncs delayed to stay aligned
   always_ff @(posedge clk) begin
      if (rst || !ctrl[0])
         uo_rgb <= '0;
      else
         uo_rgb <= {vsync_in, hsync_in,
                    visible ? to_bgr(pick) : 6'b0};
   end

   // Combinational register read
   always_comb begin
      data_out = '0;
      case (address)
         A_CTRL:   data_out[7:0]        = ctrl;
         A_STATUS: data_out[0]          = frame_pend;
         A_FCNT:   data_out[FCNT_W-1:0] = fcnt;
         A_BG:     data_out[5:0]        = bg;
         default: begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
               if (spd_hit[i]) begin
                  data_out[SPEED_W-1:0] = dx[i];
                  data_out[SPEED_W+7:8] = dy[i];
               end
               if (ofs_hit[i]) begin
                  data_out[COORD_W-1:0]   = x_ofs[i];
                  data_out[COORD_W+15:16] = y_ofs[i];
               end
            end
         end
      endcase
   end

endmodule

// File: tb/tb_bg_layer_compositor.sv
// Randomised bench for bg_layer_compositor against a register-level model.
// Interrupt expectations follow BGLC_FRAME_IRQ_EN.
`timescale 1ns/1ps
module tb_bg_layer_compositor;

   localparam int N  = 3;
   localparam int CW = 11;
   localparam int SW = 4;
   localparam int FW = 16;
   localparam int CMASK = 'h80 | ((1 << (N + 1)) - 1);
`ifdef BGLC_FRAME_IRQ_EN
   localparam int IRQ = 1;
`else
   localparam int IRQ = 0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [5:0]    address;
   logic [31:0]   data_in;
   logic [1:0]    data_write_n;
   logic [1:0]    data_read_n;
   logic [31:0]   data_out;
   logic          data_ready;
   logic          user_interrupt;
   logic [CW-1:0] pix_x;
   logic [CW-1:0] pix_y;
   logic          visible;
   logic          hsync_in;
   logic          vsync_in;
   logic [N*CW-1:0] layer_x;
   logic [N*CW-1:0] layer_y;
   logic [N*7-1:0]  layer_pix;
   logic [7:0]      uo_rgb;

   int checks = 0;
   int errors = 0;

   int m_ctrl, m_bg, m_fcnt, m_irq;
   int m_dx[N], m_dy[N], m_xo[N], m_yo[N];
   int m_pv[N], m_px[N], m_py[N];

   bg_layer_compositor #(
      .NUM_LAYERS (N),
      .COORD_W    (CW),
      .SPEED_W    (SW),
      .FCNT_W     (FW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .address        (address),
      .data_in        (data_in),
      .data_write_n   (data_write_n),
      .data_read_n    (data_read_n),
      .data_out       (data_out),
      .data_ready     (data_ready),
      .user_interrupt (user_interrupt),
      .pix_x          (pix_x),
      .pix_y          (pix_y),
      .visible        (visible),
      .hsync_in       (hsync_in),
      .vsync_in       (vsync_in),
      .layer_x        (layer_x),
      .layer_y        (layer_y),
      .layer_pix      (layer_pix),
      .uo_rgb         (uo_rgb)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   function automatic int sx(input int v);
      return (v >= 8) ? v - 16 : v;
   endfunction

   function automatic int wrap(input int v);
      return ((v % 2048) + 2048) % 2048;
   endfunction

   function automatic void m_reset();
      m_ctrl = 0; m_bg = 0; m_fcnt = 0; m_irq = 0;
      for (int i = 0; i < N; i++) begin
         m_dx[i] = 0; m_dy[i] = 0; m_xo[i] = 0; m_yo[i] = 0;
         m_pv[i] = 0; m_px[i] = 0; m_py[i] = 0;
      end
   endfunction

   function automatic void m_frame();
      if ((m_ctrl & 1) != 0) begin
         m_fcnt = (m_fcnt + 1) % 65536;
         for (int i = 0; i < N; i++) begin
            if (m_pv[i] != 0) begin
               m_xo[i] = m_px[i];
               m_yo[i] = m_py[i];
               m_pv[i] = 0;
            end else if (((m_ctrl >> (i + 1)) & 1) != 0) begin
               m_xo[i] = wrap(m_xo[i] + sx(m_dx[i]));
               m_yo[i] = wrap(m_yo[i] + sx(m_dy[i]));
            end
         end
      end
   endfunction

   function automatic void m_write(input int a, input int d);
      if (a == 'h00) m_ctrl = d & CMASK;
      else if (a == 'h04) begin
         if ((d & 1) != 0) m_irq = 0;
      end
      else if (a == 'h0C) m_bg = d & 63;
      for (int i = 0; i < N; i++) begin
         if (a == 'h10 + 4 * i) begin
            m_dx[i] = d & 15;
            m_dy[i] = (d >> 8) & 15;
         end
         if (a == 'h20 + 4 * i) begin
            m_pv[i] = 1;
            m_px[i] = d & 2047;
            m_py[i] = (d >> 16) & 2047;
         end
      end
   endfunction

   function automatic int m_read(input int a);
      int r;
      r = 0;
      if (a == 'h00) r = m_ctrl;
      if (a == 'h04) r = (IRQ != 0) ? m_irq : 0;
      if (a == 'h08) r = m_fcnt;
      if (a == 'h0C) r = m_bg;
      for (int i = 0; i < N; i++) begin
         if (a == 'h10 + 4 * i) r = m_dx[i] | (m_dy[i] << 8);
         if (a == 'h20 + 4 * i) r = m_xo[i] | (m_yo[i] << 16);
      end
      return r;
   endfunction

   // One bus cycle, optionally with a vsync rising edge
   task automatic cycle(input bit fr, input bit wr, input int a,
                        input int d);
      int set, evs;
      @(negedge clk);
      if (wr) begin
         address      = 6'(a);
         data_in      = d;
         data_write_n = 2'b10;
      end
      if (fr) vsync_in = 1'b1;
      evs = m_ctrl & 1;
      set = (fr && (m_ctrl & 1) != 0 && (m_ctrl & 'h80) != 0) ? 1 : 0;
      if (fr) m_frame();
      if (wr) m_write(a, d);
      if (set != 0) m_irq = 1;
      @(posedge clk);
      #1;
      data_write_n = 2'b11;
      if (fr) begin
         check("vsync_out", 32'(uo_rgb[7]), evs);
         @(negedge clk);
         vsync_in = 1'b0;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic rd(input int a, output int d);
      address = 6'(a);
      #1;
      d = data_out;
   endtask

   task automatic check_regs();
      int d;
      for (int a = 0; a < 64; a += 4) begin
         rd(a, d);
         check($sformatf("reg%02h", a), d, m_read(a));
      end
      check("irq", 32'(user_interrupt), (IRQ != 0) ? m_irq : 0);
   endtask

   task automatic pix_check(input int px, input int lp, input bit vis,
                            input bit hs);
      int col, bgr, exp;
      @(negedge clk);
      pix_x     = CW'(px);
      pix_y     = CW'($urandom);
      layer_pix = (N*7)'(lp);
      visible   = vis;
      hsync_in  = hs;
      #1;
      for (int i = 0; i < N; i++) begin
         check("layer_x", 32'(layer_x[i*CW +: CW]),
               wrap(int'(pix_x) + m_xo[i]));
         check("layer_y", 32'(layer_y[i*CW +: CW]),
               wrap(int'(pix_y) + m_yo[i]));
      end
      exp = 0;
      if ((m_ctrl & 1) != 0) begin
         col = m_bg;
         for (int i = N - 1; i >= 0; i--)
            if (((m_ctrl >> (i + 1)) & 1) != 0 &&
                ((lp >> (i * 7 + 6)) & 1) != 0)
               col = (lp >> (i * 7)) & 63;
         if (!vis) col = 0;
         bgr = ((col & 3) << 4) | (col & 12) | ((col >> 4) & 3);
         exp = (int'(vsync_in) << 7) | (int'(hs) << 6) | bgr;
      end
      @(posedge clk);
      #1;
      check("uo_rgb", 32'(uo_rgb), exp);
   endtask

   initial begin
      int d, op, a;
      rst          = 1'b1;
      address      = '0;
      data_in      = '0;
      data_write_n = 2'b11;
      data_read_n  = 2'b11;
      pix_x        = '0;
      pix_y        = '0;
      visible      = 1'b0;
      hsync_in     = 1'b0;
      vsync_in     = 1'b0;
      layer_pix    = '0;
      m_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_uo", 32'(uo_rgb), 0);
      check("rst_ready", 32'(data_ready), 1);
      @(negedge clk);
      rst = 1'b0;
      check_regs();

      // speed and enable
      cycle(0, 1, 'h10, 'h0F03);
      cycle(0, 1, 'h00, 'h03);
      repeat (4) cycle(1, 0, 0, 0);
      rd('h20, d);
      check("t1_ofs0", d, 32'h07FC_000C);
      rd('h08, d);
      check("t1_fcnt", d, 4);
      check_regs();

      // x wrap and coordinate
      cycle(0, 1, 'h20, 'h7FE);
      cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 0);
      rd('h20, d);
      check("t2_xofs", d & 'h7FF, 1);
      pix_check(5, 0, 1, 0);
      check("t2_lx", 32'(layer_x[CW-1:0]), 6);

      // priority
      cycle(0, 1, 'h0C, 'h2A);
      cycle(0, 1, 'h00, 'h07);
      pix_check(9, ('h4C << 7) | 'h70, 1, 0);
      check("t3_l0", 32'(uo_rgb[5:0]), 'h03);
      pix_check(9, ('h4C << 7) | 'h30, 1, 0);
      check("t3_l1", 32'(uo_rgb[5:0]), 'h0C);
      pix_check(9, ('h0C << 7) | 'h30, 1, 0);
      check("t3_bg", 32'(uo_rgb[5:0]), 'h2A);

      // blanking keeps sync
      pix_check(7, 'h70, 0, 1);
      check("t4_blank", 32'(uo_rgb), 'h40);

      // interrupt
      cycle(0, 1, 'h00, 'h83);
      cycle(1, 0, 0, 0);
      check("t5_set", 32'(user_interrupt), IRQ);
      cycle(1, 1, 'h04, 1);
      check("t5_race", 32'(user_interrupt), IRQ);
      cycle(0, 1, 'h04, 1);
      check("t5_clr", 32'(user_interrupt), 0);
      check_regs();

      // random traffic
      for (int it = 0; it < 300; it++) begin
         op = $urandom_range(0, 10);
         a  = 4 * $urandom_range(0, 15);
         d  = $urandom;
         if (a == 0 && $urandom_range(0, 3) != 0) d = d | 1;
         if (op <= 3) begin
            cycle(0, 1, a, d);
            check_regs();
         end else if (op <= 5) begin
            cycle(1, 0, 0, 0);
            check_regs();
         end else if (op == 10) begin
            cycle(1, 1, a, d);
            check_regs();
         end else begin
            pix_check($urandom % 2048, $urandom,
                      $urandom_range(0, 3) != 0, 1'($urandom));
         end
      end

      // reset mid-frame with pending writes
      cycle(0, 1, 'h00, 'h8F);
      cycle(0, 1, 'h10, 'h0102);
      cycle(1, 0, 0, 0);
      cycle(0, 1, 'h24, 'h0123_0456);
      pix_check(3, 'h7F, 1, 1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("t6_uo", 32'(uo_rgb), 0);
      @(negedge clk);
      rst = 1'b0;
      m_reset();
      check_regs();
      cycle(0, 1, 'h00, 'h01);
      cycle(1, 0, 0, 0);
      rd('h24, d);
      check("t6_nopend", d, 0);
      check_regs();

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
